// File: rtl/sram_stream_reader.sv
// Strided SRAM read master: fetches LENGTH words from BASE by STRIDE on port 2 and
// streams them out through a small FIFO that hides read latency and backpressure.
module sram_stream_reader #(
    parameter int ADDR_W     = 12,
    parameter int DATA_W     = 16,
    parameter int FIFO_DEPTH = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   length,
    input  logic [ADDR_W-1:0] stride,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] sram_address,
    output logic              sram_chipselect,
    output logic              sram_write,
    output logic [1:0]        sram_byteenable,
    output logic [DATA_W-1:0] sram_writedata,
    output logic              sram_clken,
    input  logic [DATA_W-1:0] sram_readdata,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last
);
    localparam int CNT_W = ADDR_W + 1;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int OCC_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] CNT_ONE = 1;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [ADDR_W-1:0]  stride_q, stride_d;
    logic [CNT_W-1:0]   len_q, len_d;
    logic [CNT_W-1:0]   issue_cnt_q, issue_cnt_d;
    logic [CNT_W-1:0]   accept_cnt_q, accept_cnt_d;
    logic               inflight_q, inflight_d;
    logic               inflight_last_q, inflight_last_d;
    logic [OCC_W-1:0]   occ_q, occ_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [DATA_W-1:0]  fifo_data_q [FIFO_DEPTH];
    logic [DATA_W-1:0]  fifo_data_d [FIFO_DEPTH];
    logic               fifo_last_q [FIFO_DEPTH];
    logic               fifo_last_d [FIFO_DEPTH];

    logic               push, pop, issue, last_issue, last_accept, room;
    logic [OCC_W:0]     pending;

    assign push = inflight_q;
    assign pop  = (occ_q != '0) && m_ready;

    // Credit: a read may only be issued if its data is guaranteed a FIFO slot.
    assign pending = {1'b0, occ_q} + {{OCC_W{1'b0}}, inflight_q} - {{OCC_W{1'b0}}, pop};
    assign room    = pending < (OCC_W + 1)'(FIFO_DEPTH);

    assign issue       = (state_q == S_ISSUE) && room && (issue_cnt_q != len_q);
    assign last_issue  = (issue_cnt_q == len_q - CNT_ONE);
    assign last_accept = pop && (accept_cnt_q == len_q - CNT_ONE);

    always_comb begin
        state_d         = state_q;
        addr_d          = addr_q;
        stride_d        = stride_q;
        len_d           = len_q;
        issue_cnt_d     = issue_cnt_q;
        accept_cnt_d    = accept_cnt_q;
        inflight_d      = issue;
        inflight_last_d = issue && last_issue;
        occ_d           = occ_q;
        rd_ptr_d        = rd_ptr_q;
        wr_ptr_d        = wr_ptr_q;
        fifo_data_d     = fifo_data_q;
        fifo_last_d     = fifo_last_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    addr_d       = base_addr;
                    stride_d     = stride;
                    len_d        = length;
                    issue_cnt_d  = '0;
                    accept_cnt_d = '0;
                    state_d      = (length == '0) ? S_DONE : S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (issue) begin
                    addr_d      = addr_q + stride_q;
                    issue_cnt_d = issue_cnt_q + CNT_ONE;
                    if (last_issue) state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (last_accept) state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase

        if (pop) accept_cnt_d = accept_cnt_q + CNT_ONE;

        // Data returns the cycle after issue; the in-flight flag is the push strobe.
        if (push) begin
            fifo_data_d[wr_ptr_q] = sram_readdata;
            fifo_last_d[wr_ptr_q] = inflight_last_q;
            wr_ptr_d              = wr_ptr_q + 1'b1;
        end
        if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
        occ_d = occ_q + OCC_W'(push) - OCC_W'(pop);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= S_IDLE;
            addr_q          <= '0;
            stride_q        <= '0;
            len_q           <= '0;
            issue_cnt_q     <= '0;
            accept_cnt_q    <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            occ_q           <= '0;
            rd_ptr_q        <= '0;
            wr_ptr_q        <= '0;
        end else begin
            state_q         <= state_d;
            addr_q          <= addr_d;
            stride_q        <= stride_d;
            len_q           <= len_d;
            issue_cnt_q     <= issue_cnt_d;
            accept_cnt_q    <= accept_cnt_d;
            inflight_q      <= inflight_d;
            inflight_last_q <= inflight_last_d;
            occ_q           <= occ_d;
            rd_ptr_q        <= rd_ptr_d;
            wr_ptr_q        <= wr_ptr_d;
        end
    end

    // Storage needs no reset: occupancy alone decides what is visible.
    always_ff @(posedge clk) begin
        fifo_data_q <= fifo_data_d;
        fifo_last_q <= fifo_last_d;
    end

    assign busy            = (state_q != S_IDLE);
    assign done            = (state_q == S_DONE);
    assign sram_address    = addr_q;
    assign sram_chipselect = issue;
    assign sram_write      = 1'b0;
    assign sram_byteenable = 2'b11;
    assign sram_writedata  = '0;
    assign sram_clken      = 1'b1;
    assign m_valid         = (occ_q != '0);
    assign m_data          = fifo_data_q[rd_ptr_q];
    assign m_last          = m_valid && fifo_last_q[rd_ptr_q];

endmodule
